// File: rtl/trap_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_trigger_ctrl
// Purpose  : Producer side of the PC register's trg redirect interface.
//            Synchronises and edge-detects an asynchronous external trigger.
//            It holds the trigger as a pending request. When the request is
//            enabled and no handler is active, it issues a one-cycle trg_o
//            redirect pulse and captures the return PC (EPC). Re-entry is
//            blocked until the core reports return-from-handler. Every trap
//            that is taken is counted in a saturating counter.
// Ports    : clk          system clock, rising edge
//            rst          asynchronous reset, active low
//            trg_src_i    raw external trigger, asynchronous to clk
//            enable_i     global trap enable (masks firing, keeps pending)
//            ret_i        one-cycle handler-return pulse
//            PC_Next_i    next sequential PC (return address)
//            trg_o        one-cycle redirect pulse
//            EPC_o        saved return PC
//            busy_o       high while in FIRE or HANDLER
//            pending_o    latched trigger not yet serviced
//            trap_cnt_o   saturating count of traps taken
// Revision : 1.0  initial release
// ============================================================================
module trap_trigger_ctrl #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trg_src_i,
    input  logic                 enable_i,
    input  logic                 ret_i,
    input  logic [WIDTH-1:0]     PC_Next_i,
    output logic                 trg_o,
    output logic [WIDTH-1:0]     EPC_o,
    output logic                 busy_o,
    output logic                 pending_o,
    output logic [CNT_WIDTH-1:0] trap_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FIRE    = 2'd1,
        HANDLER = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic s1;
    logic s2;
    logic s3;
    logic rise;
    logic fire_start;

    // Three-flop chain. s1/s2 resolve metastability. s3 is the delayed copy
    // used for edge detection, so a level-held trigger yields one rise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= trg_src_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise       = s2 & ~s3;
    assign fire_start = (state == IDLE) & pending_o & enable_i;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs
    always_comb begin
        state_next = state;
        trg_o      = 1'b0;
        busy_o     = 1'b0;
        case (state)
            IDLE: begin
                if (pending_o && enable_i) begin
                    state_next = FIRE;
                end
            end
            FIRE: begin
                trg_o      = 1'b1;
                busy_o     = 1'b1;
                state_next = HANDLER;
            end
            HANDLER: begin
                busy_o = 1'b1;
                if (ret_i) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pending latch, EPC capture and trap counter. A rise that coincides with
    // the IDLE->FIRE edge wins over the clear, so that trigger is kept for a
    // later trap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_o  <= 1'b0;
            EPC_o      <= '0;
            trap_cnt_o <= '0;
        end else begin
            if (rise) begin
                pending_o <= 1'b1;
            end else if (fire_start) begin
                pending_o <= 1'b0;
            end

            if (fire_start) begin
                EPC_o <= PC_Next_i;
                if (trap_cnt_o != {CNT_WIDTH{1'b1}}) begin
                    trap_cnt_o <= trap_cnt_o + CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_trigger_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_trigger_ctrl
// Purpose  : Self-checking bench for trap_trigger_ctrl. It drives two
//            instances from the same inputs: one with the default 8-bit
//            counter and one with a 2-bit counter to reach saturation. An
//            event-level model predicts every output on each cycle. Literal
//            checks pin the key scenarios.
// Revision : 1.0  initial release
// ============================================================================
module tb_trap_trigger_ctrl;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             trg_src_i = 1'b0;
    logic             enable_i = 1'b0;
    logic             ret_i = 1'b0;
    logic [WIDTH-1:0] PC_Next_i = '0;

    logic             trg_a, busy_a, pend_a;
    logic [WIDTH-1:0] epc_a;
    logic [7:0]       cnt_a;
    logic             trg_b, busy_b, pend_b;
    logic [WIDTH-1:0] epc_b;
    logic [1:0]       cnt_b;

    int n_pass = 0;
    int n_total = 0;

    trap_trigger_ctrl #(.WIDTH(WIDTH), .CNT_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .trg_src_i(trg_src_i), .enable_i(enable_i),
        .ret_i(ret_i), .PC_Next_i(PC_Next_i), .trg_o(trg_a), .EPC_o(epc_a),
        .busy_o(busy_a), .pending_o(pend_a), .trap_cnt_o(cnt_a)
    );

    trap_trigger_ctrl #(.WIDTH(WIDTH), .CNT_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .trg_src_i(trg_src_i), .enable_i(enable_i),
        .ret_i(ret_i), .PC_Next_i(PC_Next_i), .trg_o(trg_b), .EPC_o(epc_b),
        .busy_o(busy_b), .pending_o(pend_b), .trap_cnt_o(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- model ----------------
    // Trigger samples per edge since reset. The rise seen just before edge e
    // comes from input high at edge e-2 and low at edge e-3.
    bit             hist[$];
    int             edge_no;
    bit             m_pending;
    bit             m_busy;
    int             m_fire_edge;
    logic [WIDTH-1:0] m_epc;
    int             m_cnt8;
    int             m_cnt2;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist        = '{0, 0, 0};
            edge_no     = 0;
            m_pending   = 0;
            m_busy      = 0;
            m_fire_edge = -10;
            m_epc       = '0;
            m_cnt8      = 0;
            m_cnt2      = 0;
        end else begin
            bit rise_prev;
            bit fire_now;
            bit in_handler;
            edge_no++;
            rise_prev  = hist[hist.size()-2] && !hist[hist.size()-3];
            fire_now   = !m_busy && m_pending && enable_i;
            in_handler = m_busy && (edge_no - 1 > m_fire_edge);
            if (rise_prev)     m_pending = 1;
            else if (fire_now) m_pending = 0;
            if (fire_now) begin
                m_busy      = 1;
                m_fire_edge = edge_no;
                m_epc       = PC_Next_i;
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3)   m_cnt2++;
            end else if (in_handler && ret_i) begin
                m_busy = 0;
            end
            hist.push_back(trg_src_i);
            if (hist.size() > 3) void'(hist.pop_front());
        end
    end

    // Per-cycle comparison mid-cycle
    always @(negedge clk) begin
        bit m_trg;
        m_trg = m_busy && (m_fire_edge == edge_no);
        chk("trg_a",  64'(trg_a),  64'(m_trg));
        chk("busy_a", 64'(busy_a), 64'(m_busy));
        chk("pend_a", 64'(pend_a), 64'(m_pending));
        chk("epc_a",  64'(epc_a),  64'(m_epc));
        chk("cnt_a",  64'(cnt_a),  64'(m_cnt8));
        chk("trg_b",  64'(trg_b),  64'(m_trg));
        chk("busy_b", 64'(busy_b), 64'(m_busy));
        chk("pend_b", 64'(pend_b), 64'(m_pending));
        chk("epc_b",  64'(epc_b),  64'(m_epc));
        chk("cnt_b",  64'(cnt_b),  64'(m_cnt2));
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_ret();
        ret_i = 1'b1;
        tick(1);
        ret_i = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
    endtask

    initial begin
        tick(2);
        // reset state
        chk("rst_trg",  64'(trg_a),  64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
        chk("rst_pend", 64'(pend_a), 64'd0);
        chk("rst_epc",  64'(epc_a),  64'd0);
        chk("rst_cnt",  64'(cnt_a),  64'd0);
        rst = 1'b1;
        tick(2);

        // Single trigger, latency
        enable_i  = 1'b1;
        PC_Next_i = 32'h0000_0010;
        trg_src_i = 1'b1;
        tick(2);
        chk("single_pend_e2", 64'(pend_a), 64'd0);
        tick(1);
        chk("single_pend_e3", 64'(pend_a), 64'd1);
        chk("single_trg_e3",  64'(trg_a),  64'd0);
        tick(1);
        chk("single_trg_e4",  64'(trg_a),  64'd1);
        chk("single_epc",     64'(epc_a),  64'h10);
        chk("single_cnt",     64'(cnt_a),  64'd1);
        chk("single_pend_e4", 64'(pend_a), 64'd0);
        PC_Next_i = 32'h0000_0099;
        tick(1);
        chk("single_trg_e5",  64'(trg_a),  64'd0);
        chk("single_busy",    64'(busy_a), 64'd1);
        tick(5);
        chk("single_hold",    64'(busy_a), 64'd1);
        do_ret();
        chk("single_ret",     64'(busy_a), 64'd0);
        chk("single_epc_hold", 64'(epc_a), 64'h10);
        trg_src_i = 1'b0;
        tick(4);

        // Masked
        enable_i  = 1'b0;
        trg_src_i = 1'b1;
        tick(2);
        trg_src_i = 1'b0;
        tick(20);
        chk("mask_pend", 64'(pend_a), 64'd1);
        chk("mask_busy", 64'(busy_a), 64'd0);
        PC_Next_i = 32'h0000_0020;
        enable_i  = 1'b1;
        tick(1);
        chk("mask_trg",  64'(trg_a),  64'd1);
        chk("mask_pend0", 64'(pend_a), 64'd0);
        chk("mask_epc",  64'(epc_a),  64'h20);
        tick(2);
        do_ret();
        tick(3);

        // Nested trigger
        do_reset();
        tick(2);
        PC_Next_i = 32'h0000_0030;
        trg_src_i = 1'b1;
        tick(4);
        chk("nest_trg1", 64'(trg_a), 64'd1);
        trg_src_i = 1'b0;
        tick(3);
        trg_src_i = 1'b1;
        tick(3);
        chk("nest_pend", 64'(pend_a), 64'd1);
        chk("nest_nofire", 64'(trg_a), 64'd0);
        tick(3);
        chk("nest_nofire2", 64'(trg_a), 64'd0);
        PC_Next_i = 32'h0000_0044;
        do_ret();
        chk("nest_idle", 64'(busy_a), 64'd0);
        tick(1);
        chk("nest_trg2", 64'(trg_a), 64'd1);
        chk("nest_epc",  64'(epc_a), 64'h44);
        chk("nest_cnt",  64'(cnt_a), 64'd2);
        trg_src_i = 1'b0;
        tick(2);
        do_ret();
        tick(3);

        // Set/clear collision: rise lands on the IDLE->FIRE edge
        enable_i  = 1'b0;
        trg_src_i = 1'b1;
        tick(2);
        trg_src_i = 1'b0;
        tick(4);
        chk("coll_pend0", 64'(pend_a), 64'd1);
        trg_src_i = 1'b1;
        tick(2);
        enable_i  = 1'b1;
        PC_Next_i = 32'h0000_0050;
        tick(1);
        chk("coll_trg",  64'(trg_a),  64'd1);
        chk("coll_pend", 64'(pend_a), 64'd1);
        trg_src_i = 1'b0;
        tick(2);
        PC_Next_i = 32'h0000_0054;
        do_ret();
        tick(1);
        chk("coll_trg2", 64'(trg_a), 64'd1);
        chk("coll_epc2", 64'(epc_a), 64'h54);
        chk("coll_pend2", 64'(pend_a), 64'd0);
        tick(2);
        do_ret();
        tick(3);

        // Saturation: 2-bit counter reads 1,2,3,3,3
        do_reset();
        tick(2);
        for (int i = 0; i < 5; i++) begin
            logic [1:0] exp2;
            exp2 = (i < 3) ? 2'(i + 1) : 2'd3;
            PC_Next_i = 32'h100 + 32'(i * 4);
            trg_src_i = 1'b1;
            tick(4);
            chk("sat_trg",   64'(trg_b), 64'd1);
            chk("sat_cnt2",  64'(cnt_b), 64'(exp2));
            chk("sat_cnt8",  64'(cnt_a), 64'(i + 1));
            trg_src_i = 1'b0;
            tick(1);
            do_ret();
            tick(3);
        end

        // Async reset mid-handler with pending
        PC_Next_i = 32'h0000_0070;
        trg_src_i = 1'b1;
        tick(4);
        trg_src_i = 1'b0;
        tick(3);
        trg_src_i = 1'b1;
        tick(2);
        trg_src_i = 1'b0;
        tick(2);
        chk("ar_pre_pend", 64'(pend_a), 64'd1);
        chk("ar_pre_busy", 64'(busy_a), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_busy", 64'(busy_a), 64'd0);
        chk("ar_pend", 64'(pend_a), 64'd0);
        chk("ar_trg",  64'(trg_a),  64'd0);
        chk("ar_epc",  64'(epc_a),  64'd0);
        chk("ar_cnt",  64'(cnt_a),  64'd0);
        chk("ar_cnt2", 64'(cnt_b),  64'd0);
        tick(2);
        rst = 1'b1;
        tick(10);
        chk("ar_post_pend", 64'(pend_a), 64'd0);
        chk("ar_post_busy", 64'(busy_a), 64'd0);
        PC_Next_i = 32'h0000_0080;
        trg_src_i = 1'b1;
        tick(4);
        chk("ar_new_trg", 64'(trg_a), 64'd1);
        chk("ar_new_epc", 64'(epc_a), 64'h80);
        chk("ar_new_cnt", 64'(cnt_a), 64'd1);
        trg_src_i = 1'b0;
        tick(2);
        do_ret();
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
